imm_extend_seq: RTL and testbench
=================================

Name: imm_extend_seq

Overview:
- Parametrised, handshaked immediate-extension unit for the ARM-style datapath.
- Adds the ARM rotated 8-bit immediate (imm8 ROR 2*rot) with shifter carry-out, computed by an iterative area-saving rotator.
- Also supports 12-bit zero-extend and 24-bit branch sign-extend-shift, with WIDTH-generic output.
- Sits between the decoder and the ALU operand mux; valid/ready on both sides.

Parameters:
- WIDTH, 32, output width. Legal values are 32 and 64.
- STEP_BITS, 2, rotate bits per ROTATE cycle. Legal values are even numbers 2..30.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- instr_field  input  24  instruction bits [23:0].
- imm_src  input  2  mode: 00 rotated imm8; 01 unsigned imm12; 10 branch imm24; 11 illegal.
- carry_in  input  1  current C flag, passed through when the rotate amount is 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- ext_imm  output  WIDTH  extended immediate.
- carry_out  output  1  shifter carry.
- err  output  1  illegal imm_src flagged with this result.

Behaviour:
- Reset is synchronous and active-high; clk is the only clock.
- On reset: state=IDLE; out_valid=0, ext_imm=0, carry_out=0, err=0; in_ready=1 the cycle after reset.
- Reset asserted in any state, including mid-ROTATE, aborts the operation. The pending result is discarded and never presented.
- Accept: in_valid & in_ready at a clk edge. All inputs are sampled only at accept; later changes on them are ignored.
- in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - This allows one result per cycle for non-rotating requests.
  - While in ROTATE, in_valid is ignored.
- States:
  - IDLE: out_valid=0.
  - ROTATE: out_valid=0, in_ready=0.
  - HOLD: out_valid=1; ext_imm, carry_out and err are stable until the handshake.
- Transitions at accept:
  - imm_src=00 with rot!=0 -> ROTATE.
  - All other requests -> HOLD, with the result registered at the accept edge.
- In HOLD with out_ready=1: accept in the same cycle if in_valid=1 (per the rules above), else -> IDLE.
- Mode 00 (rotated imm8):
  - imm8=instr_field[7:0], rot=instr_field[11:8], amount=2*rot (0..30).
  - At accept: working reg = {24'b0, imm8}, remaining = amount.
  - Each ROTATE cycle rotates the 32-bit working reg right by min(STEP_BITS, remaining) and subtracts that from remaining.
  - ROTATE -> HOLD on the edge where remaining reaches 0.
  - Rotation is always within 32 bits. ext_imm = result zero-extended to WIDTH.
  - carry_out = result bit 31 if rot!=0, else the sampled carry_in.
  - Latency from accept edge to out_valid = 1 + ceil(amount/STEP_BITS) cycles.
- Mode 01: ext_imm = zero-extend(instr_field[11:0]); carry_out = sampled carry_in; latency 1.
- Mode 10: ext_imm = sign-extend to WIDTH of {instr_field[23:0], 2'b00}; carry_out = sampled carry_in; latency 1.
- Mode 11: ext_imm=0, err=1, carry_out = sampled carry_in; latency 1.
  - err is cleared on the next accepted legal request or on reset.
- Simultaneous handshake in HOLD: the output handshake and the new accept occur on the same edge. The new result overwrites the outputs and out_valid stays 1, or the unit goes to ROTATE with out_valid=0 if the new request rotates.

Test Plan:
- Rotate with carry: imm_src=00, instr_field=0x0004FF (imm8=0xFF, rot=4), STEP_BITS=2 -> out_valid 5 cycles after accept, ext_imm=0xFF000000, carry_out=1.
- Max rotate: instr_field=0x000F01 -> ext_imm=0x00000004, carry_out=0, latency 16. Repeat with STEP_BITS=8 -> latency 5, same value.
- Zero rotate and imm12: mode 00, instr_field=0x0000AB, carry_in=1 -> 0x000000AB, carry_out=1, latency 1. Mode 01, instr_field=0xABCFFF -> 0x00000FFF.
- Branch back-to-back with out_ready=1, WIDTH=32: instr_field=0xFFFFFE -> 0xFFFFFFF8, then 0x000010 -> 0x00000040 on consecutive cycles, with in_ready held 1. With WIDTH=64, 0xFFFFFE -> 0xFFFFFFFFFFFFFFF8.
- Backpressure: out_ready=0 for 3 cycles in HOLD -> ext_imm/carry_out stable, in_ready=0, new in_valid ignored. The result is consumed on the first out_ready=1 cycle.
- Reset and illegal mode:
  - Reset asserted 2 cycles into the 0x0004FF rotation -> next cycle out_valid=0, in_ready=1, ext_imm=0.
  - imm_src=11 -> err=1, ext_imm=0, latency 1.
  - Following mode-01 request -> err=0.

Source files
------------

// File: rtl/imm_extend_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : imm_extend_seq
//  Purpose  : Handshaked immediate extender (rotated imm8, imm12, branch imm24)
//             with an iterative rotator for the ARM rotated-immediate form.
//  Revision : 1.0  initial release
// ============================================================================
module imm_extend_seq #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      instr_field,
  input  logic [1:0]       imm_src,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ext_imm,
  output logic             carry_out,
  output logic             err
);

  localparam logic [4:0] c_STEP    = 5'(STEP_BITS);
  localparam logic [1:0] c_SRC_ROT = 2'b00;
  localparam logic [1:0] c_SRC_U12 = 2'b01;
  localparam logic [1:0] c_SRC_BR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_work;
  logic [4:0]       r_remain;
  logic [WIDTH-1:0] r_ext_imm;
  logic             r_carry_out;
  logic             r_err;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_start_rot;
  logic [3:0]       w_rot_field;
  logic [4:0]       w_step;
  logic [4:0]       w_rem_nxt;
  logic [31:0]      w_rot;
  logic             w_rot_done;
  logic [WIDTH-1:0] w_direct_imm;
  logic             w_direct_err;

  assign w_rot_field = instr_field[11:8];
  assign w_start_rot = (imm_src == c_SRC_ROT) && (w_rot_field != 4'd0);

  // Final partial step handles amounts that are not a multiple of STEP_BITS.
  assign w_step     = (r_remain < c_STEP) ? r_remain : c_STEP;
  assign w_rem_nxt  = r_remain - w_step;
  assign w_rot      = (r_work >> w_step) | (r_work << (6'd32 - 6'(w_step)));
  assign w_rot_done = (w_rem_nxt == 5'd0);

  // Result for every request that completes at the accept edge.
  always_comb begin
    w_direct_imm = '0;
    w_direct_err = 1'b0;
    case (imm_src)
      c_SRC_ROT: w_direct_imm = WIDTH'(instr_field[7:0]);
      c_SRC_U12: w_direct_imm = WIDTH'(instr_field[11:0]);
      c_SRC_BR:  w_direct_imm = WIDTH'($signed({instr_field, 2'b00}));
      default:   w_direct_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
      end
      ST_ROTATE: begin
        if (w_rot_done) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_accept = in_valid & w_in_ready;
    if (w_accept) begin
      w_state_nxt = w_start_rot ? ST_ROTATE : ST_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_work      <= '0;
      r_remain    <= '0;
      r_ext_imm   <= '0;
      r_carry_out <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_direct_err;
      if (w_start_rot) begin
        r_work   <= {24'd0, instr_field[7:0]};
        r_remain <= {w_rot_field, 1'b0};
      end else begin
        r_ext_imm   <= w_direct_imm;
        r_carry_out <= carry_in;
      end
    end else if (r_state == ST_ROTATE) begin
      r_work   <= w_rot;
      r_remain <= w_rem_nxt;
      if (w_rot_done) begin
        r_ext_imm   <= WIDTH'(w_rot);
        r_carry_out <= w_rot[31];
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign ext_imm   = r_ext_imm;
  assign carry_out = r_carry_out;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for imm_extend_seq: three instances (32/step2, 32/step8,
// 64/step2) share one stimulus stream; expected values are hand-computed.
module tb_imm_extend_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        carry_in = 1'b0;
  logic [23:0] instr_field = '0;
  logic [1:0]  imm_src = '0;

  logic        in_ready, out_valid, carry_out, err;
  logic [31:0] ext_imm;
  logic        b_in_ready, b_out_valid, b_carry, b_err;
  logic [31:0] b_ext;
  logic        c_in_ready, c_out_valid, c_carry, c_err;
  logic [63:0] c_ext;

  int checks = 0;
  int errors = 0;
  int lat_a, lat_b, lat_c;

  always #5 clk = ~clk;

  imm_extend_seq #(.WIDTH(32), .STEP_BITS(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_field(instr_field), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .ext_imm(ext_imm),
    .carry_out(carry_out), .err(err));

  imm_extend_seq #(.WIDTH(32), .STEP_BITS(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr_field(instr_field), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(b_out_valid), .out_ready(out_ready), .ext_imm(b_ext),
    .carry_out(b_carry), .err(b_err));

  imm_extend_seq #(.WIDTH(64), .STEP_BITS(2)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .instr_field(instr_field), .imm_src(imm_src), .carry_in(carry_in),
    .out_valid(c_out_valid), .out_ready(out_ready), .ext_imm(c_ext),
    .carry_out(c_carry), .err(c_err));

  // One request, then record per-instance latency over a 20-cycle window
  // with the consumer stalled; inputs are scrambled after the accept edge.
  task automatic issue(input logic [1:0] src, input logic [23:0] fld, input logic cin);
    @(negedge clk);
    imm_src = src; instr_field = fld; carry_in = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; instr_field = 24'h5A5A5A; carry_in = ~cin;
    lat_a = 0; lat_b = 0; lat_c = 0;
    for (int k = 1; k <= 20; k++) begin
      if (out_valid   && lat_a == 0) lat_a = k;
      if (b_out_valid && lat_b == 0) lat_b = k;
      if (c_out_valid && lat_c == 0) lat_c = k;
      if (k < 20) begin @(posedge clk); #1; end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
    checks++; if (ext_imm !== 32'h0) begin errors++; $display("FAIL rst_ext got %0h exp 0", ext_imm); end
    checks++; if ({carry_out, err} !== 2'b00) begin errors++; $display("FAIL rst_carry_err got %0h exp 0", {carry_out, err}); end
    checks++; if ({b_out_valid, b_in_ready, b_carry, b_err, b_ext} !== {4'b0100, 32'h0}) begin
      errors++; $display("FAIL rst_dut8 got %0h exp %0h", {b_out_valid, b_in_ready, b_carry, b_err, b_ext}, {4'b0100, 32'h0}); end
    checks++; if ({c_out_valid, c_in_ready, c_carry, c_err, c_ext} !== {4'b0100, 64'h0}) begin
      errors++; $display("FAIL rst_dut64 got %0h exp %0h", {c_out_valid, c_in_ready, c_carry, c_err, c_ext}, {4'b0100, 64'h0}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_rotate_carry();
    issue(2'b00, 24'h0004FF, 1'b0);
    checks++; if (lat_a != 5) begin errors++; $display("FAIL rot_latency got %0d exp 5", lat_a); end
    checks++; if (ext_imm !== 32'hFF000000) begin errors++; $display("FAIL rot_ext got %0h exp ff000000", ext_imm); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL rot_carry got %0h exp 1", carry_out); end
    checks++; if (lat_b != 2) begin errors++; $display("FAIL rot8_latency got %0d exp 2", lat_b); end
    checks++; if (b_ext !== 32'hFF000000) begin errors++; $display("FAIL rot8_ext got %0h exp ff000000", b_ext); end
    consume();
  endtask

  task automatic test_max_rotate();
    issue(2'b00, 24'h000F01, 1'b1);
    checks++; if (lat_a != 16) begin errors++; $display("FAIL max_latency got %0d exp 16", lat_a); end
    checks++; if (ext_imm !== 32'h00000004) begin errors++; $display("FAIL max_ext got %0h exp 4", ext_imm); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL max_carry got %0h exp 0", carry_out); end
    checks++; if (lat_b != 5) begin errors++; $display("FAIL max8_latency got %0d exp 5", lat_b); end
    checks++; if (b_ext !== 32'h00000004) begin errors++; $display("FAIL max8_ext got %0h exp 4", b_ext); end
    checks++; if (lat_c != 16 || c_ext !== 64'h4) begin errors++; $display("FAIL max64 got lat %0d ext %0h exp lat 16 ext 4", lat_c, c_ext); end
    consume();
  endtask

  task automatic test_zero_rot_imm12();
    issue(2'b00, 24'h0000AB, 1'b1);
    checks++; if (lat_a != 1) begin errors++; $display("FAIL zrot_latency got %0d exp 1", lat_a); end
    checks++; if (ext_imm !== 32'h000000AB) begin errors++; $display("FAIL zrot_ext got %0h exp ab", ext_imm); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL zrot_carry got %0h exp 1", carry_out); end
    consume();
    issue(2'b01, 24'hABCFFF, 1'b0);
    checks++; if (lat_a != 1) begin errors++; $display("FAIL imm12_latency got %0d exp 1", lat_a); end
    checks++; if (ext_imm !== 32'h00000FFF) begin errors++; $display("FAIL imm12_ext got %0h exp fff", ext_imm); end
    checks++; if (c_ext !== 64'h0000000000000FFF) begin errors++; $display("FAIL imm12_ext64 got %0h exp fff", c_ext); end
    consume();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    imm_src = 2'b10; instr_field = 24'hFFFFFE; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || ext_imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL b2b_first got v %0h ext %0h exp v 1 ext fffffff8", out_valid, ext_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0h exp 1", in_ready); end
    checks++; if (c_ext !== 64'hFFFFFFFFFFFFFFF8) begin errors++; $display("FAIL b2b_ext64 got %0h exp fffffffffffffff8", c_ext); end
    instr_field = 24'h000010;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || ext_imm !== 32'h00000040) begin errors++; $display("FAIL b2b_second got v %0h ext %0h exp v 1 ext 40", out_valid, ext_imm); end
    checks++; if (c_ext !== 64'h40) begin errors++; $display("FAIL b2b_second64 got %0h exp 40", c_ext); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0h exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(2'b01, 24'hABCFFF, 1'b0);
    checks++; if (ext_imm !== 32'h00000FFF || carry_out !== 1'b0) begin errors++; $display("FAIL bp_initial got ext %0h c %0h exp fff 0", ext_imm, carry_out); end
    imm_src = 2'b01; instr_field = 24'h000123; carry_in = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (ext_imm !== 32'h00000FFF || carry_out !== 1'b0) begin errors++; $display("FAIL bp_stable got ext %0h c %0h exp fff 0", ext_imm, carry_out); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hs got rdy %0h v %0h exp 0 1", in_ready, out_valid); end
    end
    in_valid = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0 || ext_imm !== 32'h00000FFF) begin errors++; $display("FAIL bp_consumed got v %0h ext %0h exp 0 fff", out_valid, ext_imm); end
  endtask

  task automatic test_reset_mid_rotate();
    int late;
    @(negedge clk);
    imm_src = 2'b00; instr_field = 24'h0004FF; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %0h exp 1", in_ready); end
    checks++; if (ext_imm !== 32'h0) begin errors++; $display("FAIL midrst_ext got %0h exp 0", ext_imm); end
    late = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid || b_out_valid || c_out_valid) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL midrst_late_valid got %0d exp 0", late); end
  endtask

  task automatic test_illegal();
    issue(2'b11, 24'h000FFF, 1'b1);
    checks++; if (lat_a != 1) begin errors++; $display("FAIL ill_latency got %0d exp 1", lat_a); end
    checks++; if (err !== 1'b1 || ext_imm !== 32'h0) begin errors++; $display("FAIL ill_err got err %0h ext %0h exp 1 0", err, ext_imm); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL ill_carry got %0h exp 1", carry_out); end
    consume();
    issue(2'b01, 24'h000123, 1'b0);
    checks++; if (err !== 1'b0 || ext_imm !== 32'h00000123) begin errors++; $display("FAIL ill_clear got err %0h ext %0h exp 0 123", err, ext_imm); end
    consume();
  endtask

  initial begin
    test_reset();
    test_rotate_carry();
    test_max_rotate();
    test_zero_rot_imm12();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_rotate();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
